// File: rtl/max_product_state_sweep_pkg.sv
// Shared metric type, saturation constants and saturating helpers for the max-product sweep.
// Latency: n/a (combinational functions only).
// Backpressure: n/a.
// Functions work on a wide signed carrier so callers of any BITS (<= 31) share them;
// the caller passes its metric width and narrows the result back.
package max_product_state_sweep_pkg;

  localparam int METRIC_BITS = 16;
  typedef logic signed [METRIC_BITS-1:0] metric_t;

  // NEG_INF is reserved as "impossible path"; the saturating range excludes it.
  localparam metric_t NEG_INF = {1'b1, {(METRIC_BITS-1){1'b0}}};
  localparam metric_t MAX_POS = {1'b0, {(METRIC_BITS-1){1'b1}}};

  localparam int WIDE_BITS = 32;
  typedef logic signed [WIDE_BITS-1:0] wide_t;

  function automatic wide_t neg_inf_w(input int bits);
    return -(wide_t'(1) <<< (bits - 1));
  endfunction

  function automatic wide_t max_pos_w(input int bits);
    return (wide_t'(1) <<< (bits - 1)) - wide_t'(1);
  endfunction

  // NEG_INF is absorbing; everything else clamps symmetrically.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int bits);
    wide_t ni;
    wide_t mp;
    wide_t s;
    ni = neg_inf_w(bits);
    mp = max_pos_w(bits);
    if (a == ni || b == ni) return ni;
    s = a + b;
    if (s > mp) s = mp;
    else if (s < -mp) s = -mp;
    return s;
  endfunction

  function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int bits);
    wide_t ni;
    wide_t mp;
    wide_t s;
    ni = neg_inf_w(bits);
    mp = max_pos_w(bits);
    if (a == ni || b == ni) return ni;
    s = a - b;
    if (s > mp) s = mp;
    else if (s < -mp) s = -mp;
    return s;
  endfunction

  function automatic wide_t max2(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/max_product_state_sweep_masked_max.sv
// Masked maximum over WIDTH signed metrics; an empty mask yields NEG_INF.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
// Ports: vals (WIDTH x BITS metrics), mask (1 = candidate), max_val (BITS result).
module max_product_masked_max
  import max_product_state_sweep_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int BITS  = 16
) (
  input  logic [WIDTH-1:0][BITS-1:0] vals,
  input  logic [WIDTH-1:0]           mask,
  output logic [BITS-1:0]            max_val
);

  function automatic logic [BITS-1:0] nar(input wide_t x);
    return x[BITS-1:0];
  endfunction

  always_comb begin : p_max
    wide_t acc;
    acc = neg_inf_w(BITS);
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) acc = max2(acc, wide_t'($signed(vals[i])));
    end
    max_val = nar(acc);
  end

endmodule

// File: rtl/max_product_state_sweep.sv
// Max-product backward (beta) sweep for one trellis state per transfer, with per-bit LLR maxima.
// Latency: 3 register stages from input transfer to out_valid; one state per cycle.
// Backpressure: single global enable (en = !out_valid || out_ready); all stages stall together.
// Ports: clk/rst; in_valid/in_ready with branch_metric, old_beta, alpha, branch_bits;
//        out_valid/out_ready with beta, llr_0, llr_1, out_state, out_step_last.
module max_product_state_sweep
  import max_product_state_sweep_pkg::*;
#(
  parameter int BITS          = 16,
  parameter int INPUT_SYMBOLS = 2,
  parameter int OUTPUT_BITS   = 2,
  parameter int NUM_STATES    = 4,
  parameter int NORMALIZE     = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [INPUT_SYMBOLS-1:0][BITS-1:0]         branch_metric,
  input  logic [INPUT_SYMBOLS-1:0][BITS-1:0]         old_beta,
  input  logic [BITS-1:0]                            alpha,
  input  logic [INPUT_SYMBOLS-1:0][OUTPUT_BITS-1:0]  branch_bits,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [BITS-1:0]                            beta,
  output logic [OUTPUT_BITS-1:0][BITS-1:0]           llr_0,
  output logic [OUTPUT_BITS-1:0][BITS-1:0]           llr_1,
  output logic [$clog2(NUM_STATES)-1:0]              out_state,
  output logic                                       out_step_last
);

  localparam int SW = $clog2(NUM_STATES);
  localparam logic [SW-1:0]   LAST_STATE = SW'(NUM_STATES - 1);
  localparam logic [BITS-1:0] NEG_INF_B  = {1'b1, {(BITS-1){1'b0}}};

  function automatic wide_t wid(input logic [BITS-1:0] x);
    return wide_t'($signed(x));
  endfunction

  function automatic logic [BITS-1:0] nar(input wide_t x);
    return x[BITS-1:0];
  endfunction

  logic en;
  logic in_xfer;
  logic out_xfer;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign in_xfer  = in_valid && en;
  assign out_xfer = out_valid && out_ready;

  // State index assigned at input time so it travels down the pipe with the data.
  logic [SW-1:0] state_cnt;

  // Stage 1 registers
  logic                                      v1;
  logic [INPUT_SYMBOLS-1:0][BITS-1:0]        s1_sum;
  logic [BITS-1:0]                           s1_alpha;
  logic [INPUT_SYMBOLS-1:0][OUTPUT_BITS-1:0] s1_bits;
  logic [SW-1:0]                             s1_state;
  logic                                      s1_last;

  // Stage 2 registers
  logic                                      v2;
  logic [BITS-1:0]                           s2_b;
  logic [INPUT_SYMBOLS-1:0][BITS-1:0]        s2_om;
  logic [INPUT_SYMBOLS-1:0][OUTPUT_BITS-1:0] s2_bits;
  logic [SW-1:0]                             s2_state;
  logic                                      s2_last;

  // Stage 3 keeps the raw b next to the visible beta for step_max tracking.
  logic [BITS-1:0] s3_b;
  logic [BITS-1:0] step_max;
  logic [BITS-1:0] norm_offset;

  logic [INPUT_SYMBOLS-1:0][BITS-1:0] sum_d;
  logic [INPUT_SYMBOLS-1:0][BITS-1:0] om_d;
  logic [BITS-1:0]                    b_d;
  logic [OUTPUT_BITS-1:0][BITS-1:0]   llr0_d;
  logic [OUTPUT_BITS-1:0][BITS-1:0]   llr1_d;
  logic [BITS-1:0]                    step_max_fold;
  logic [BITS-1:0]                    offset_eff;
  logic [BITS-1:0]                    beta_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < INPUT_SYMBOLS; i++) begin
      sum_d[i] = nar(sat_add(wid(branch_metric[i]), wid(old_beta[i]), BITS));
    end
  end

  always_comb begin : p_stage2
    wide_t acc;
    acc  = neg_inf_w(BITS);
    om_d = '0;
    for (int i = 0; i < INPUT_SYMBOLS; i++) begin
      acc     = max2(acc, wid(s1_sum[i]));
      om_d[i] = nar(sat_add(wid(s1_sum[i]), wid(s1_alpha), BITS));
    end
    b_d = nar(acc);
  end

  for (genvar g = 0; g < OUTPUT_BITS; g++) begin : g_llr
    logic [INPUT_SYMBOLS-1:0] bit_one;

    always_comb begin
      bit_one = '0;
      for (int i = 0; i < INPUT_SYMBOLS; i++) bit_one[i] = s2_bits[i][g];
    end

    max_product_masked_max #(.WIDTH(INPUT_SYMBOLS), .BITS(BITS)) u_max_0 (
      .vals    (s2_om),
      .mask    (~bit_one),
      .max_val (llr0_d[g])
    );

    max_product_masked_max #(.WIDTH(INPUT_SYMBOLS), .BITS(BITS)) u_max_1 (
      .vals    (s2_om),
      .mask    (bit_one),
      .max_val (llr1_d[g])
    );
  end

  // The first state of a new step can enter stage 3 on the same edge the last state
  // of the previous step leaves, so the freshly folded offset is forwarded here.
  always_comb begin
    step_max_fold = nar(max2(wid(step_max), wid(s3_b)));
    offset_eff    = norm_offset;
    if (NORMALIZE == 0) offset_eff = '0;
    else if (out_xfer && out_step_last) offset_eff = step_max_fold;
    beta_d = s2_b;
    if (NORMALIZE != 0) beta_d = nar(sat_sub(wid(s2_b), wid(offset_eff), BITS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_cnt <= '0;
    end else if (in_xfer) begin
      state_cnt <= (state_cnt == LAST_STATE) ? '0 : state_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1            <= 1'b0;
      s1_sum        <= '0;
      s1_alpha      <= '0;
      s1_bits       <= '0;
      s1_state      <= '0;
      s1_last       <= 1'b0;
      v2            <= 1'b0;
      s2_b          <= '0;
      s2_om         <= '0;
      s2_bits       <= '0;
      s2_state      <= '0;
      s2_last       <= 1'b0;
      out_valid     <= 1'b0;
      beta          <= '0;
      s3_b          <= '0;
      llr_0         <= '0;
      llr_1         <= '0;
      out_state     <= '0;
      out_step_last <= 1'b0;
    end else if (en) begin
      v1            <= in_valid;
      s1_sum        <= sum_d;
      s1_alpha      <= alpha;
      s1_bits       <= branch_bits;
      s1_state      <= state_cnt;
      s1_last       <= (state_cnt == LAST_STATE);
      v2            <= v1;
      s2_b          <= b_d;
      s2_om         <= om_d;
      s2_bits       <= s1_bits;
      s2_state      <= s1_state;
      s2_last       <= s1_last;
      out_valid     <= v2;
      beta          <= beta_d;
      s3_b          <= s2_b;
      llr_0         <= llr0_d;
      llr_1         <= llr1_d;
      out_state     <= s2_state;
      out_step_last <= s2_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_max    <= NEG_INF_B;
      norm_offset <= '0;
    end else if (out_xfer) begin
      if (out_step_last) begin
        norm_offset <= (NORMALIZE != 0) ? step_max_fold : '0;
        step_max    <= NEG_INF_B;
      end else begin
        step_max    <= step_max_fold;
      end
    end
  end

endmodule

// File: tb/tb_max_product_state_sweep.sv
`timescale 1ns/1ps
module tb_max_product_state_sweep;

  localparam int BITS = 16;
  localparam int IS   = 2;
  localparam int OB   = 2;
  localparam int NS   = 4;
  localparam int NEG  = -32768;
  localparam int MAXP = 32767;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    in_valid = 1'b0;
  logic                    out_ready = 1'b1;
  logic [IS-1:0][BITS-1:0] branch_metric = '0;
  logic [IS-1:0][BITS-1:0] old_beta = '0;
  logic [BITS-1:0]         alpha = '0;
  logic [IS-1:0][OB-1:0]   branch_bits = '0;

  logic                    in_ready, out_valid, out_step_last;
  logic [BITS-1:0]         beta;
  logic [OB-1:0][BITS-1:0] llr_0, llr_1;
  logic [1:0]              out_state;

  logic                    r_in_ready, r_out_valid, r_out_step_last;
  logic [BITS-1:0]         r_beta;
  logic [OB-1:0][BITS-1:0] r_llr_0, r_llr_1;
  logic [1:0]              r_out_state;

  max_product_state_sweep #(.BITS(BITS), .INPUT_SYMBOLS(IS), .OUTPUT_BITS(OB),
                            .NUM_STATES(NS), .NORMALIZE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .branch_metric(branch_metric), .old_beta(old_beta), .alpha(alpha),
    .branch_bits(branch_bits), .out_valid(out_valid), .out_ready(out_ready),
    .beta(beta), .llr_0(llr_0), .llr_1(llr_1), .out_state(out_state),
    .out_step_last(out_step_last)
  );

  max_product_state_sweep #(.BITS(BITS), .INPUT_SYMBOLS(IS), .OUTPUT_BITS(OB),
                            .NUM_STATES(NS), .NORMALIZE(0)) u_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready),
    .branch_metric(branch_metric), .old_beta(old_beta), .alpha(alpha),
    .branch_bits(branch_bits), .out_valid(r_out_valid), .out_ready(out_ready),
    .beta(r_beta), .llr_0(r_llr_0), .llr_1(r_llr_1), .out_state(r_out_state),
    .out_step_last(r_out_step_last)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [BITS-1:0] x);
    return int'($signed(x));
  endfunction

  // Reference arithmetic straight from the metric rules.
  function automatic int sat(input int x);
    if (x > MAXP) return MAXP;
    if (x < -MAXP) return -MAXP;
    return x;
  endfunction
  function automatic int add(input int a, input int b);
    if (a == NEG || b == NEG) return NEG;
    return sat(a + b);
  endfunction
  function automatic int sub(input int a, input int b);
    if (a == NEG || b == NEG) return NEG;
    return sat(a - b);
  endfunction
  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  typedef struct packed {
    int beta; int raw; int l00; int l01; int l10; int l11; int st; int last;
  } exp_t;

  exp_t q[$];
  int   seen[$];
  int   m_state = 0;
  int   m_off   = 0;
  int   m_cur   = NEG;

  // Model works per step: the offset for a step is the max raw b of the previous step.
  task automatic model_push();
    int   s, b;
    int   om [IS];
    int   l0 [OB];
    int   l1 [OB];
    exp_t e;
    b = NEG;
    for (int i = 0; i < IS; i++) begin
      s     = add(sx(branch_metric[i]), sx(old_beta[i]));
      b     = mx(b, s);
      om[i] = add(s, sx(alpha));
    end
    for (int g = 0; g < OB; g++) begin
      l0[g] = NEG;
      l1[g] = NEG;
      for (int i = 0; i < IS; i++) begin
        if (branch_bits[i][g]) l1[g] = mx(l1[g], om[i]);
        else                   l0[g] = mx(l0[g], om[i]);
      end
    end
    e.raw  = b;
    e.beta = sub(b, m_off);
    e.l00  = l0[0]; e.l01 = l0[1]; e.l10 = l1[0]; e.l11 = l1[1];
    e.st   = m_state;
    e.last = (m_state == NS - 1) ? 1 : 0;
    m_cur  = mx(m_cur, b);
    if (m_state == NS - 1) begin
      m_off = m_cur;
      m_cur = NEG;
    end
    m_state = (m_state + 1) % NS;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      m_state = 0;
      m_off   = 0;
      m_cur   = NEG;
    end else begin
      if (r_out_valid !== out_valid) chk("raw_valid_match", int'(r_out_valid), int'(out_valid));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = q[0];
          chk("cmp_beta",  sx(beta),     e.beta);
          chk("cmp_raw",   sx(r_beta),   e.raw);
          chk("cmp_l0_0",  sx(llr_0[0]), e.l00);
          chk("cmp_l0_1",  sx(llr_0[1]), e.l01);
          chk("cmp_l1_0",  sx(llr_1[0]), e.l10);
          chk("cmp_l1_1",  sx(llr_1[1]), e.l11);
          chk("cmp_state", int'(out_state), e.st);
          chk("cmp_last",  int'(out_step_last), e.last);
          if (out_ready) begin
            void'(q.pop_front());
            seen.push_back(int'(out_state));
          end
        end
      end
      if (in_valid && in_ready) model_push();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int bm0, input int bm1, input int ob0, input int ob1,
                      input int al, input logic [1:0] bt0, input logic [1:0] bt1);
    bit ok;
    branch_metric[0] = 16'(bm0);
    branch_metric[1] = 16'(bm1);
    old_beta[0]      = 16'(ob0);
    old_beta[1]      = 16'(ob1);
    alpha            = 16'(al);
    branch_bits[0]   = bt0;
    branch_bits[1]   = bt1;
    in_valid         = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) chk("out_timeout", 0, 1);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
    tick();
  endtask

  function automatic int rnd_m();
    case ($urandom_range(0, 7))
      0: return NEG;
      1: return MAXP;
      2: return -MAXP;
      3: return int'($urandom_range(0, 65535)) - 32768;
      default: return int'($urandom_range(0, 2000)) - 1000;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals [4];
    int hold_low;
    vals = '{7, 40, 12, 3};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_beta",      sx(beta), 0);
    chk("rst_out_state", int'(out_state), 0);
    chk("rst_llr_0",     sx(llr_0[0]), 0);
    tick();

    // Basic: sums {15,21}, om {18,24}
    send(10, 20, 5, 1, 3, 2'b00, 2'b11);
    wait_out();
    chk("basic_beta",  sx(beta), 21);
    chk("basic_l0_0",  sx(llr_0[0]), 18);
    chk("basic_l0_1",  sx(llr_0[1]), 18);
    chk("basic_l1_0",  sx(llr_1[0]), 24);
    chk("basic_l1_1",  sx(llr_1[1]), 24);
    chk("basic_state", int'(out_state), 0);
    tick();

    // Empty branch sets
    send(10, 20, 5, 1, 3, 2'b01, 2'b01);
    wait_out();
    chk("empty_l0_0", sx(llr_0[0]), NEG);
    chk("empty_l1_0", sx(llr_1[0]), 24);
    chk("empty_l0_1", sx(llr_0[1]), 24);
    chk("empty_l1_1", sx(llr_1[1]), NEG);
    tick();

    // Saturation and NEG_INF absorption
    send(MAXP, 0, 100, NEG, 0, 2'b00, 2'b11);
    wait_out();
    chk("sat_beta", sx(beta), MAXP);
    chk("sat_l0_0", sx(llr_0[0]), MAXP);
    chk("sat_l1_0", sx(llr_1[0]), NEG);
    tick();

    // Normalization across a step boundary
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(vals[k], 0, 0, NEG, 0, 2'b00, 2'b11);
      wait_out();
      chk("norm_step0_beta", sx(beta), vals[k]);
      tick();
    end
    send(50, 0, 0, NEG, 0, 2'b00, 2'b11);
    wait_out();
    chk("norm_beta",     sx(beta), 10);
    chk("norm_raw_beta", sx(r_beta), 50);
    chk("norm_state",    int'(out_state), 0);
    tick();

    // Backpressure during a continuous stream
    do_reset();
    seen.delete();
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(100 + 10 * k, 5, k, -3, 7, 2'(k), 2'(~k));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_out_valid",    int'(out_valid), 1);
        chk("bp_in_ready_low", int'(in_ready), 0);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", seen.size(), 8);
    for (int k = 0; k < 8; k++)
      chk("bp_state_seq", (seen.size() > k) ? seen[k] : -1, k % 4);

    // Reset mid-step discards in-flight data and the offset
    send(200, 0, 0, NEG, 0, 2'b00, 2'b11);
    send(300, 0, 0, NEG, 0, 2'b00, 2'b11);
    send(250, 0, 0, NEG, 0, 2'b00, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold_low = 1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (out_valid) hold_low = 0;
    end
    chk("rst_mid_no_valid", hold_low, 1);
    tick();
    send(30, 0, 0, NEG, 0, 2'b00, 2'b11);
    wait_out();
    chk("rst_mid_state", int'(out_state), 0);
    chk("rst_mid_beta",  sx(beta), 30);
    tick();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst              = ($urandom_range(0, 99) == 0);
      in_valid         = ($urandom_range(0, 3) != 0);
      out_ready        = ($urandom_range(0, 3) != 0);
      branch_metric[0] = 16'(rnd_m());
      branch_metric[1] = 16'(rnd_m());
      old_beta[0]      = 16'(rnd_m());
      old_beta[1]      = 16'(rnd_m());
      alpha            = 16'(rnd_m());
      branch_bits      = 4'($urandom_range(0, 15));
      tick();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
